game_result_select: RTL and testbench



---
 rtl/game_pkg.sv | 25 ++
 rtl/hold_timer.sv | 41 ++++
 rtl/game_result_select.sv | 130 +++++++++++++
 tb/tb_game_result_select.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game result path: FSM state encoding,
// result width and the mode numbers that index the selector channels.
package game_pkg;

    localparam int unsigned RESULT_W     = 5;

    localparam int unsigned MODE_REGULAR = 0;
    localparam int unsigned MODE_EVENODD = 1;
    localparam int unsigned MODE_RAND    = 2;
    localparam int unsigned NUM_MODES    = MODE_RAND + 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StHold   = 2'd1,
        StSwitch = 2'd2
    } state_e;

    // Width of a down-counter that must hold values 0..hold; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned hold);
        int unsigned w;
        w = $clog2(hold + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that times the display-hold interval; zero_o flags expiry.
module hold_timer
    import game_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic load_i,
    input  logic clear_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int unsigned CntW = cnt_width(HOLD_CYCLES);
    localparam logic [CntW-1:0] LoadVal = CntW'(HOLD_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = LoadVal;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/game_result_select.sv
// Registered N-channel result selector: valid/ready capture from the selected engine,
// minimum display hold after each capture, and a one-cycle flush-to-zero on mode change.
module game_result_select
    import game_pkg::*;
#(
    parameter int unsigned WIDTH       = RESULT_W,
    parameter int unsigned CHANNELS    = NUM_MODES,
    parameter int unsigned SEL_W       = 2,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic                      out_hold,
    output logic                      sel_err
);

    // One extra bit so CHANNELS == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0] ChanLim = (SEL_W + 1)'(CHANNELS);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               sel_err_q, sel_err_d;

    logic               sel_change;
    logic               sel_ok;
    logic               capture;
    logic [WIDTH-1:0]   chan_data;
    logic               tmr_load, tmr_clear, tmr_dec, tmr_zero;

    assign sel_change = (sel != sel_q);
    assign sel_ok     = ({1'b0, sel_q} < ChanLim);

    always_comb begin
        in_ready  = '0;
        chan_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                chan_data   = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = (state_q == StIdle) && !sel_change && sel_ok;
            end
        end
    end

    assign capture = |(in_valid & in_ready);

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .resetn (resetn),
        .load_i (tmr_load),
        .clear_i(tmr_clear),
        .dec_i  (tmr_dec),
        .zero_o (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        sel_err_d   = sel_err_q;
        tmr_load    = 1'b0;
        tmr_clear   = 1'b0;
        tmr_dec     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (sel_change) begin
                    state_d = StSwitch;
                end else if (capture) begin
                    state_d     = StHold;
                    out_data_d  = chan_data;
                    out_valid_d = 1'b1;
                    tmr_load    = 1'b1;
                end
            end
            StHold: begin
                // A mode change abandons the hold even on the expiry cycle.
                if (sel_change) begin
                    state_d   = StSwitch;
                    tmr_clear = 1'b1;
                end else if (tmr_zero) begin
                    state_d = StIdle;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            StSwitch: begin
                out_data_d = '0;
                sel_d      = sel;
                sel_err_d  = ({1'b0, sel} >= ChanLim);
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            sel_q       <= SEL_W'(MODE_REGULAR);
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_hold  = (state_q == StHold);
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_game_result_select.sv
// Randomised and directed bench for game_result_select with a cycle model and a
// scoreboard queue drained by an independent output monitor.
module tb_game_result_select;

    localparam int unsigned W    = 5;
    localparam int unsigned CH   = 3;
    localparam int unsigned SW   = 2;
    localparam int unsigned HOLD = 4;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [CH*W-1:0]   in_data = '0;
    logic [CH-1:0]     in_valid = '0;
    logic [CH-1:0]     in_ready;
    logic [SW-1:0]     sel = '0;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_hold;
    logic              sel_err;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    game_result_select #(
        .WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .out_data(out_data), .out_valid(out_valid),
        .out_hold(out_hold), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: active mode, pending flush, remaining hold cycles.
    int unsigned   m_active = 0;
    bit            m_switch = 1'b0;
    int unsigned   m_hold_left = 0;
    bit            m_err = 1'b0;
    int unsigned   m_data = 0;
    bit            m_valid = 1'b0;
    int unsigned   sb_q[$];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_active    <= 0;
            m_switch    <= 1'b0;
            m_hold_left <= 0;
            m_err       <= 1'b0;
            m_data      <= 0;
            m_valid     <= 1'b0;
            sb_q.delete();
        end else begin
            m_valid <= 1'b0;
            if (m_switch) begin
                m_switch <= 1'b0;
                m_active <= int'(sel);
                m_err    <= (int'(sel) >= CH);
                m_data   <= 0;
            end else if (int'(sel) != m_active) begin
                m_switch    <= 1'b1;
                m_hold_left <= 0;
            end else if (m_hold_left > 0) begin
                m_hold_left <= m_hold_left - 1;
            end else if (m_active < CH && in_valid[m_active]) begin
                m_data      <= int'(in_data[m_active*W +: W]);
                m_valid     <= 1'b1;
                m_hold_left <= HOLD;
                sb_q.push_back(int'(in_data[m_active*W +: W]));
            end
        end
    end

    function automatic int unsigned exp_ready();
        if (!m_switch && m_hold_left == 0 && int'(sel) == m_active && m_active < CH)
            return 1 << m_active;
        return 0;
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", int'(out_valid), int'(m_valid));
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_capture", 1, 0);
                end else begin
                    chk("captured_data", int'(out_data), sb_q.pop_front());
                end
            end
            chk("out_data", int'(out_data), m_data);
            chk("out_hold", int'(out_hold), int'(m_hold_left > 0));
            chk("sel_err", int'(sel_err), int'(m_err));
            chk("in_ready", int'(in_ready), exp_ready());
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive(input logic [CH-1:0] v, input int d0, input int d1, input int d2);
        in_valid = v;
        in_data  = {W'(d2), W'(d1), W'(d0)};
    endtask

    initial begin
        resetn = 1'b0;
        step(2);
        mon_en = 1'b1;
        resetn = 1'b1;
        step(2);

        // Basic capture, then sustained back-pressure with ch1 also valid.
        drive(3'b001, 23, 0, 0);
        step(1);
        drive(3'b000, 0, 0, 0);
        chk("basic_data", int'(out_data), 23);
        step(6);
        drive(3'b011, 9, 7, 0);
        step(14);
        drive(3'b000, 0, 0, 0);
        step(2);

        // Mode switch during hold.
        drive(3'b001, 23, 0, 0);
        step(1);
        sel = 2'd2;
        drive(3'b000, 0, 0, 0);
        step(3);
        drive(3'b100, 0, 0, 31);
        step(1);
        drive(3'b000, 0, 0, 0);
        chk("switch_capture", int'(out_data), 31);
        step(6);

        // Simultaneous select change and valid.
        sel = 2'd0;
        step(4);
        sel = 2'd1;
        drive(3'b011, 4, 12, 0);
        step(6);
        drive(3'b000, 0, 0, 0);
        step(5);

        // Out-of-range select.
        sel = 2'd3;
        for (int i = 0; i < 14; i++) begin
            drive(CH'($urandom), $urandom, $urandom, $urandom);
            step(1);
        end
        chk("oor_err", int'(sel_err), 1);
        sel = 2'd1;
        drive(3'b000, 0, 0, 0);
        step(3);
        chk("oor_clear", int'(sel_err), 0);

        // Asynchronous reset mid-hold.
        sel = 2'd0;
        step(3);
        drive(3'b001, 17, 0, 0);
        step(1);
        drive(3'b000, 0, 0, 0);
        step(1);
        chk("pre_reset_data", int'(out_data), 17);
        chk("pre_reset_hold", int'(out_hold), 1);
        resetn = 1'b0;
        #1;
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_hold", int'(out_hold), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_sel_err", int'(sel_err), 0);
        step(2);
        resetn = 1'b1;
        #1;
        chk("rst_release_ready", int'(in_ready), 1);
        step(1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) sel = SW'($urandom_range(0, 3));
            drive(CH'($urandom), $urandom, $urandom, $urandom);
            step(1);
        end
        drive(3'b000, 0, 0, 0);
        step(HOLD + 3);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
